instr_loader: RTL and testbench

Parametrised front-end that assembles a multi-beat CPU instruction from a narrow switch bank, one beat per push-button press. It synchronises, debounces and edge-detects the button, fills the instruction register LSB beat first, and presents the completed word to the CPU core over a valid/ready handshake. It also drives a 7-segment status digit showing the next expected beat. It sits between the board I/O pins and the bit-serial core's instruction register, replacing ad-hoc two-half loading.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/instr_loader_if.sv | 8 +
 rtl/btn_conditioner.sv | 37 +++
 rtl/instr_loader.sv | 63 ++++++
 tb/tb_instr_loader.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state type and 7-segment hex glyphs for the instruction loader
package cpu_pkg;
  typedef enum logic {S_COLLECT = 1'b0, S_FULL = 1'b1} state_t;
  // segments {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: valid/ready instruction handoff from the loader to the CPU core
interface instr_loader_if #(parameter int INSTR_W = 16) ();
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               instr_ready;
  modport master (output instr_out, output instr_valid, input instr_ready);
  modport slave  (input instr_out, input instr_valid, output instr_ready);
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: button synchroniser, debouncer and rising-edge strobe
module btn_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, level_q, rise_q, s;
  logic [CW-1:0] cnt_q, cnt_d;
  assign s = sync_q[SYNC_STAGES-1];
  // counts consecutive edges that sampled the same synchronised level, this one included
  assign cnt_d = (s != prev_q) ? CW'(1) : (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
      prev_q  <= s;
      cnt_q   <= cnt_d;
      level_q <= (cnt_d == CMAX) ? s : level_q;
      rise_q  <= (cnt_d == CMAX) && s && !level_q;
    end
  end
  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: assembles a multi-beat instruction from switches, one beat per button press
module instr_loader
  import cpu_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int NBEATS      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] sw_in,
  input  logic            btn_in,
  input  logic            abort,
  instr_loader_if.master  bus,
  output logic [3:0]      beat_idx,
  output logic [6:0]      seg_out
);
  localparam int INSTR_W = IN_W * NBEATS;
  localparam logic [3:0] LAST = 4'(NBEATS - 1);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, level, rise, strobe;
  logic [6:0] seg_q;
  btn_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_btn (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level), .rise(rise)
  );
  assign strobe = rise & level;
  // abort outranks a strobe; in S_FULL abort and transfer both just return to collection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    if (state_q == S_FULL) state_d = (bus.instr_ready || abort) ? S_COLLECT : S_FULL;
    else if (abort) idx_d = '0;
    else if (strobe) begin
      for (int b = 0; b < NBEATS; b++)
        if (idx_q == 4'(b)) instr_d[b*IN_W +: IN_W] = sw_in;
      state_d = (idx_q == LAST) ? S_FULL : S_COLLECT;
      idx_d   = (idx_q == LAST) ? 4'd0 : idx_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      idx_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      seg_q   <= SEG_HEX[0];
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
      valid_q <= state_d == S_FULL;
      seg_q   <= SEG_HEX[(state_d == S_FULL) ? 4'hF : idx_d];
    end
  end
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign beat_idx        = idx_q;
  assign seg_out         = seg_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized bench for two loader configurations against an event-level model
module tb_instr_loader;
  localparam int S_A = 2, D_A = 4, N_A = 2;
  localparam int S_B = 3, D_B = 5, N_B = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] sw_a, sw_b;
  logic btn_a, btn_b, abort_a, abort_b;
  logic [3:0] beat_a, beat_b;
  logic [6:0] seg_a, seg_b;
  instr_loader_if #(.INSTR_W(8*N_A)) bus_a ();
  instr_loader_if #(.INSTR_W(8*N_B)) bus_b ();
  instr_loader #(.IN_W(8), .NBEATS(N_A), .SYNC_STAGES(S_A), .DB_CYCLES(D_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_a), .btn_in(btn_a), .abort(abort_a),
    .bus(bus_a), .beat_idx(beat_a), .seg_out(seg_a)
  );
  instr_loader #(.IN_W(8), .NBEATS(N_B), .SYNC_STAGES(S_B), .DB_CYCLES(D_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_b), .btn_in(btn_b), .abort(abort_b),
    .bus(bus_b), .beat_idx(beat_b), .seg_out(seg_b)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int n_chk = 0, n_err = 0;
  logic [7:0] m_word [2][3];
  int m_idx [2];
  bit m_full [2];
  int nb [2] = '{N_A, N_B};
  int lat_exp [2] = '{S_A + D_A + 1, S_B + D_B + 1};
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u] = 0;
      m_full[u] = 1'b0;
      for (int b = 0; b < 3; b++) m_word[u][b] = 8'h00;
    end
  endtask
  task automatic set_btn(int u, logic v, logic [7:0] d);
    if (u == 0) begin btn_a = v; sw_a = d; end else begin btn_b = v; sw_b = d; end
  endtask
  task automatic set_ctl(int u, logic rdy, logic ab);
    if (u == 0) begin bus_a.instr_ready = rdy; abort_a = ab; end
    else begin bus_b.instr_ready = rdy; abort_b = ab; end
  endtask
  function automatic logic [4:0] sig(int u);
    return (u == 0) ? {bus_a.instr_valid, beat_a} : {bus_b.instr_valid, beat_b};
  endfunction
  task automatic check_unit(int u, string tag);
    logic [23:0] e = '0;
    for (int b = 0; b < nb[u]; b++) e[b*8 +: 8] = m_word[u][b];
    chk({tag, ".instr"}, (u == 0) ? {8'h0, bus_a.instr_out} : bus_b.instr_out, e);
    chk({tag, ".valid"}, (u == 0) ? bus_a.instr_valid : bus_b.instr_valid, m_full[u]);
    chk({tag, ".beat"}, (u == 0) ? beat_a : beat_b, m_full[u] ? 0 : m_idx[u]);
    chk({tag, ".seg"}, (u == 0) ? seg_a : seg_b, m_full[u] ? GLYPH[15] : GLYPH[m_idx[u]]);
  endtask
  task automatic press(int u, logic [7:0] d, string tag);
    int lat = 0;
    logic [4:0] s0;
    bit cap = !m_full[u];
    set_btn(u, 1'b1, d);
    s0 = sig(u);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (lat == 0 && sig(u) !== s0) lat = i;
    end
    set_btn(u, 1'b0, d);
    tick(14);
    if (cap) begin
      m_word[u][m_idx[u]] = d;
      if (m_idx[u] == nb[u] - 1) begin m_idx[u] = 0; m_full[u] = 1'b1; end
      else m_idx[u]++;
    end
    chk({tag, ".latency"}, lat, cap ? lat_exp[u] : 0);
    check_unit(u, tag);
  endtask
  task automatic ctl_pulse(int u, logic rdy, logic ab, string tag);
    set_ctl(u, rdy, ab);
    tick(1);
    set_ctl(u, 1'b0, 1'b0);
    tick(1);
    if (m_full[u] && (rdy || ab)) m_full[u] = 1'b0;
    else if (ab) m_idx[u] = 0;
    check_unit(u, tag);
  endtask
  initial begin
    int u, op;
    rst_n = 1'b0;
    set_btn(0, 1'b0, 8'h00);
    set_btn(1, 1'b0, 8'h00);
    set_ctl(0, 1'b0, 1'b0);
    set_ctl(1, 1'b0, 1'b0);
    model_reset();
    tick(3);
    check_unit(0, "rst_a");
    check_unit(1, "rst_b");
    rst_n = 1'b1;
    tick(2);
    press(0, 8'h34, "a_beat0");
    press(0, 8'h12, "a_beat1");
    // glitch of 3 cycles, shorter than DB_CYCLES
    set_btn(0, 1'b1, 8'h77);
    tick(3);
    set_btn(0, 1'b0, 8'h77);
    tick(14);
    check_unit(0, "glitch_full");
    ctl_pulse(0, 1'b0, 1'b0, "idle");
    press(0, 8'hFF, "backpressure");
    ctl_pulse(0, 1'b1, 1'b0, "transfer");
    set_btn(0, 1'b1, 8'h66);
    tick(3);
    set_btn(0, 1'b0, 8'h66);
    tick(14);
    check_unit(0, "glitch_empty");
    ctl_pulse(0, 1'b1, 1'b0, "ready_idle");
    press(1, 8'hAA, "b_first");
    ctl_pulse(1, 1'b0, 1'b1, "b_abort");
    press(1, 8'hAA, "b_aa");
    press(1, 8'hBB, "b_bb");
    press(1, 8'hCC, "b_cc");
    ctl_pulse(1, 1'b1, 1'b1, "b_xfer_abort");
    press(0, 8'h56, "a_pre_coinc");
    set_btn(0, 1'b1, 8'h99);
    tick(S_A + D_A);
    set_ctl(0, 1'b0, 1'b1);
    tick(1);
    set_ctl(0, 1'b0, 1'b0);
    set_btn(0, 1'b0, 8'h99);
    tick(14);
    m_idx[0] = 0;
    check_unit(0, "abort_strobe");
    for (int k = 0; k < 60; k++) begin
      u = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      if (op < 6) press(u, 8'($urandom), "rnd_press");
      else if (op < 8) ctl_pulse(u, 1'b1, 1'b0, "rnd_xfer");
      else if (op == 8) ctl_pulse(u, 1'b0, 1'b1, "rnd_abort");
      else ctl_pulse(u, 1'b1, 1'b1, "rnd_both");
    end
    if (m_full[0]) ctl_pulse(0, 1'b1, 1'b0, "drain");
    press(0, 8'hC3, "a_pre_reset");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_unit(0, "async_rst_a");
    check_unit(1, "async_rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    press(1, 8'h5A, "b_after_rst");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
